wb_test_responder: RTL and testbench
====================================

# wb_test_responder

Wishbone B4 pipelined responder that serves the data cache's line fills and write-backs from a local word RAM. It adds a request queue, programmable pseudo-random stall injection and per-request wait states, so the cache's initiator logic is exercised under realistic back-pressure and variable latency. It sits where the plain memory model sits today, behind the cache's `wb_*` port, and is used in simulation and FPGA stress builds.

## Interface
- `AW`, 12: word-address width of `wb_adr_i`.
- `MEM_WORDS`, 1024: implemented words; addresses `>= MEM_WORDS` return an error.
- `FIFO_DEPTH`, 4: request queue entries (power of two, >= 2).
- `MAX_WAIT`, 3: maximum extra wait cycles per request (power of two minus one, 0 disables).
- `STALL_EN`, 1: enable pseudo-random stall injection.
- `LFSR_SEED`, 16'hACE1: reset value of the 16-bit LFSR (non-zero).
- `INIT_FILE`, "": optional `$readmemh` image loaded at time zero.

Ports:
- `cpu_clock_i` in 1: single clock, all logic on rising edge.
- `reset_i` in 1: asynchronous, active-high reset.
- `wb_cyc_i` in 1: bus cycle active.
- `wb_stb_i` in 1: request strobe.
- `wb_we_i` in 1: 1 = write.
- `wb_adr_i` in AW: word address.
- `wb_dat_i` in 32: write data.
- `wb_sel_i` in 4: byte enables, bit n ↔ bits 8n+7:8n.
- `wb_stall_o` out 1: request not accepted this cycle.
- `wb_ack_o` out 1: successful response, one per request.
- `wb_dat_o` out 32: read data, valid with `wb_ack_o`.
- `wb_err_o` out 1: error response (out-of-range address).

## Operation
- Accept = `wb_cyc_i & wb_stb_i & !wb_stall_o`. On accept, push {we, adr, dat, sel} into the queue.
- `wb_stall_o = full | (STALL_EN & lfsr[0])`. This is combinational from registered state only, with no input dependence. The queue being full stalls even when a pop occurs in the same cycle.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It advances every cycle outside reset.
- Wait counter: loaded when an entry becomes head, either by a push into an empty queue or by a pop leaving the queue non-empty. The load value is `lfsr[4:1] & MAX_WAIT`. It decrements each cycle while non-zero.
- Service: when the queue is non-empty and the counter is 0, pop the head and register the response.
  - In range, write: byte-masked RAM update; `ack=1`; `dat_o` holds its previous value.
  - In range, read: `dat_o = RAM[adr]`; `ack=1`.
  - Out of range: `err=1`, no RAM change, `dat_o = 0`.
- Responses are strictly in acceptance order. A read following a write to the same address returns the written bytes.
- `wb_ack_o` and `wb_err_o` are high for exactly one cycle per request and are never high together.
- `wb_cyc_i` low: the queue is flushed, the wait counter is cleared, and no ack or err is registered in that cycle or later for dropped requests. Writes already popped remain committed.
- Reset, asynchronous, held while `reset_i` is high:
  - Queue empty, counter 0, LFSR = seed.
  - `wb_ack_o = 0`, `wb_err_o = 0`, `wb_dat_o = 0`.
  - `wb_stall_o = STALL_EN & seed[0]`.
  - RAM contents are not reset.
- Reset mid-burst: outstanding requests are lost silently.

## Timing
- Zero wait, empty queue: request accepted at edge k, popped at edge k+1, `wb_ack_o` high in cycle k+1..k+2, which is two edges after acceptance.
- Throughput: one response per cycle when waits are 0 and there are no stalls. Back-to-back accepts are sustained while not full.
- Each wait cycle adds exactly one cycle to that request's response and to all later ones.
- Maximum outstanding is `FIFO_DEPTH`. Queue occupancy uses a `$clog2(FIFO_DEPTH)+1`-bit count; pointers wrap modulo `FIFO_DEPTH`.
- Simultaneous push and pop: occupancy unchanged, both take effect.

## Structure
- Package `wb_pkg`: `wb_req_t` struct {we, adr[AW], dat[32], sel[4]} (AW fixed via package parameter) and the LFSR tap constant.
- Sub-module `wb_req_fifo`: synchronous FIFO with push/pop, full/empty and asynchronous reset.
- Top level holds the LFSR, wait counter, RAM and response registers.

## Test plan
- `STALL_EN=0`, `MAX_WAIT=0`: write 32'hDEADBEEF to 0x010 with sel 4'hF, then read 0x010. Required: two acks at accept+2, read data 32'hDEADBEEF.
- Partial write: sel 4'b0010, data 32'h0000AA00 to 0x010, then read. Required: 32'hDEADAABE... i.e. only byte 1 replaced, giving 32'hDEADAAEF.
- Stall when full: 6 back-to-back reads with waits forced to 3. Required: stall high once 4 entries are outstanding, and 6 in-order acks total.
- Read of address 1024 with `MEM_WORDS=1024`. Required: `wb_err_o` pulse, no ack, `wb_dat_o = 0`.
- Drop `wb_cyc_i` with 3 requests queued. Required: no ack or err afterwards; `wb_stall_o` reflects an empty queue on the next cycle.
- Assert `reset_i` mid-burst. Required: outputs zero immediately (asynchronous), queue empty, and a fresh request after release is acked normally.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone test responder.
// Holds the queued request record and the LFSR feedback taps.
package wb_pkg;

    localparam int WB_AW = 12;

    // Fibonacci taps 16,14,13,11 map to bits 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef struct packed {
        logic             we;
        logic [WB_AW-1:0] adr;
        logic [31:0]      dat;
        logic [3:0]       sel;
    } wb_req_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/wb_req_fifo.sv
// Request queue for the Wishbone test responder.
// Power-of-two synchronous FIFO with flush and asynchronous reset of the pointers.
module wb_req_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  wb_req_t                data_i,
    output wb_req_t                data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    wb_req_t       mem_q [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign do_push = push_i & ~full_o & ~flush_i;
    assign do_pop  = pop_i & ~empty_o & ~flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/wb_test_responder.sv
// Wishbone B4 pipelined responder backed by a local word RAM, with a request
// queue, LFSR-driven stall injection and per-request random wait states.
module wb_test_responder
    import wb_pkg::*;
#(
    parameter int          AW         = 12,
    parameter int          MEM_WORDS  = 1024,
    parameter int          FIFO_DEPTH = 4,
    parameter int          MAX_WAIT   = 3,
    parameter bit          STALL_EN   = 1'b1,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter string       INIT_FILE  = ""
) (
    input  logic          cpu_clock_i,
    input  logic          reset_i,
    input  logic          wb_cyc_i,
    input  logic          wb_stb_i,
    input  logic          wb_we_i,
    input  logic [AW-1:0] wb_adr_i,
    input  logic [31:0]   wb_dat_i,
    input  logic [3:0]    wb_sel_i,
    output logic          wb_stall_o,
    output logic          wb_ack_o,
    output logic [31:0]   wb_dat_o,
    output logic          wb_err_o
);

    localparam int         MW        = $clog2(MEM_WORDS);
    localparam int         CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [3:0] WAIT_MASK = 4'(MAX_WAIT);

    logic [15:0]   lfsr_q, lfsr_d;
    logic [3:0]    wait_q, wait_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;
    logic [31:0]   dat_q, dat_d;
    logic [31:0]   mem_q [MEM_WORDS];

    wb_req_t       push_req;
    wb_req_t       head_req;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          accept;
    logic          service;
    logic          head_loaded;
    logic          in_range;
    logic          mem_we;
    logic [MW-1:0] ram_idx;

    // Stall depends on registered state only, so the initiator never sees a loop.
    assign wb_stall_o = fifo_full | (STALL_EN & lfsr_q[0]);
    assign accept     = wb_cyc_i & wb_stb_i & ~wb_stall_o;
    assign service    = wb_cyc_i & ~fifo_empty & (wait_q == '0);
    assign in_range   = 32'(head_req.adr) < 32'(MEM_WORDS);
    assign ram_idx    = head_req.adr[MW-1:0];

    // A new head appears on a push into an empty queue or a pop that leaves entries behind.
    assign head_loaded = (accept & fifo_empty) |
                         (service & ((fifo_count > CW'(1)) | accept));

    always_comb begin
        push_req     = '0;
        push_req.we  = wb_we_i;
        push_req.adr = WB_AW'(wb_adr_i);
        push_req.dat = wb_dat_i;
        push_req.sel = wb_sel_i;
    end

    wb_req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (cpu_clock_i),
        .rst_i   (reset_i),
        .flush_i (~wb_cyc_i),
        .push_i  (accept),
        .pop_i   (service),
        .data_i  (push_req),
        .data_o  (head_req),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        lfsr_d = lfsr_next(lfsr_q);
        wait_d = wait_q;
        if (!wb_cyc_i) begin
            wait_d = '0;
        end else if (head_loaded) begin
            wait_d = lfsr_q[4:1] & WAIT_MASK;
        end else if (wait_q != '0) begin
            wait_d = wait_q - 1'b1;
        end
    end

    always_comb begin
        ack_d  = 1'b0;
        err_d  = 1'b0;
        dat_d  = dat_q;
        mem_we = 1'b0;
        if (service) begin
            if (!in_range) begin
                err_d = 1'b1;
                dat_d = '0;
            end else if (head_req.we) begin
                ack_d  = 1'b1;
                mem_we = 1'b1;
            end else begin
                ack_d = 1'b1;
                dat_d = mem_q[ram_idx];
            end
        end
    end

    always_ff @(posedge cpu_clock_i or posedge reset_i) begin
        if (reset_i) begin
            lfsr_q <= LFSR_SEED;
            wait_q <= '0;
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
            dat_q  <= '0;
        end else begin
            lfsr_q <= lfsr_d;
            wait_q <= wait_d;
            ack_q  <= ack_d;
            err_q  <= err_d;
            dat_q  <= dat_d;
        end
    end

    // RAM contents deliberately survive reset.
    always_ff @(posedge cpu_clock_i) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (head_req.sel[b]) mem_q[ram_idx][8*b +: 8] <= head_req.dat[8*b +: 8];
            end
        end
    end

    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;
    assign wb_dat_o = dat_q;

endmodule

// File: tb/tb_wb_test_responder.sv
// Directed self-checking bench for wb_test_responder: A has no waits/stalls,
// B has random waits (queue fill, cyc drop), C only shows the LFSR stall pattern.
`timescale 1ns/1ps
module tb_wb_test_responder;

    localparam logic [15:0] SEED = 16'hACE1;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;

    logic        aCyc = 1'b0, aStb = 1'b0, aWe = 1'b0;
    logic [11:0] aAdr = '0;
    logic [31:0] aDat = '0;
    logic [3:0]  aSel = '0;
    logic        aStall, aAck, aErr;
    logic [31:0] aDatO;

    logic        bCyc = 1'b0, bStb = 1'b0, bWe = 1'b0;
    logic [11:0] bAdr = '0;
    logic [31:0] bDat = '0;
    logic [3:0]  bSel = '0;
    logic        bStall, bAck, bErr;
    logic [31:0] bDatO;

    logic        cStall, cAck, cErr;
    logic [31:0] cDatO;

    logic [15:0] lfsrModel;

    always @(posedge clock or posedge reset) begin
        if (reset) lfsrModel <= SEED;
        else       lfsrModel <= {lfsrModel[14:0], lfsrModel[15] ^ lfsrModel[13] ^ lfsrModel[12] ^ lfsrModel[10]};
    end

    wb_test_responder #(.AW(12), .MEM_WORDS(1024), .FIFO_DEPTH(4), .MAX_WAIT(0), .STALL_EN(1'b0), .LFSR_SEED(SEED)) dutA (
        .cpu_clock_i(clock), .reset_i(reset), .wb_cyc_i(aCyc), .wb_stb_i(aStb), .wb_we_i(aWe),
        .wb_adr_i(aAdr), .wb_dat_i(aDat), .wb_sel_i(aSel), .wb_stall_o(aStall), .wb_ack_o(aAck),
        .wb_dat_o(aDatO), .wb_err_o(aErr));

    wb_test_responder #(.AW(12), .MEM_WORDS(1024), .FIFO_DEPTH(4), .MAX_WAIT(3), .STALL_EN(1'b0), .LFSR_SEED(SEED)) dutB (
        .cpu_clock_i(clock), .reset_i(reset), .wb_cyc_i(bCyc), .wb_stb_i(bStb), .wb_we_i(bWe),
        .wb_adr_i(bAdr), .wb_dat_i(bDat), .wb_sel_i(bSel), .wb_stall_o(bStall), .wb_ack_o(bAck),
        .wb_dat_o(bDatO), .wb_err_o(bErr));

    wb_test_responder #(.AW(12), .MEM_WORDS(1024), .FIFO_DEPTH(4), .MAX_WAIT(3), .STALL_EN(1'b1), .LFSR_SEED(SEED)) dutC (
        .cpu_clock_i(clock), .reset_i(reset), .wb_cyc_i(1'b0), .wb_stb_i(1'b0), .wb_we_i(1'b0),
        .wb_adr_i(12'h000), .wb_dat_i(32'h0), .wb_sel_i(4'h0), .wb_stall_o(cStall), .wb_ack_o(cAck),
        .wb_dat_o(cDatO), .wb_err_o(cErr));

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset();
        @(negedge clock);
        vectors++; if (aStall !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_stallA: got %b want 0", aStall); end
        vectors++; if (cStall !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_stallC: got %b want 1", cStall); end
        vectors++; if ({aAck, aErr} !== 2'b00) begin miscompares++; $display("[TB] FAIL rst_ackerrA: got %b want 00", {aAck, aErr}); end
        vectors++; if (aDatO !== 32'h0) begin miscompares++; $display("[TB] FAIL rst_datA: got %h want 0", aDatO); end
        vectors++; if ({bAck, bErr, bStall} !== 3'b000) begin miscompares++; $display("[TB] FAIL rst_B: got %b want 000", {bAck, bErr, bStall}); end
        tick();
        reset = 1'b0;
        aCyc  = 1'b1;
        bCyc  = 1'b1;
    endtask

    task automatic test_stall_lfsr();
        for (int i = 0; i < 20; i++) begin
            tick();
            vectors++; if (cStall !== lfsrModel[0]) begin miscompares++; $display("[TB] FAIL lfsr_stall[%0d]: got %b want %b", i, cStall, lfsrModel[0]); end
        end
        vectors++; if ({cAck, cErr} !== 2'b00) begin miscompares++; $display("[TB] FAIL idleC: got %b want 00", {cAck, cErr}); end
    endtask

    task automatic test_write_read();
        aWe = 1'b1; aAdr = 12'h010; aDat = 32'hDEADBEEF; aSel = 4'hF; aStb = 1'b1;
        tick();
        aStb = 1'b0;
        vectors++; if (aAck !== 1'b0) begin miscompares++; $display("[TB] FAIL wr_ack_early: got %b want 0", aAck); end
        tick();
        vectors++; if ({aAck, aErr} !== 2'b10) begin miscompares++; $display("[TB] FAIL wr_ack: got %b want 10", {aAck, aErr}); end
        vectors++; if (aDatO !== 32'h0) begin miscompares++; $display("[TB] FAIL wr_dat_hold: got %h want 0", aDatO); end
        tick();
        vectors++; if (aAck !== 1'b0) begin miscompares++; $display("[TB] FAIL wr_ack_pulse: got %b want 0", aAck); end
        aWe = 1'b0; aStb = 1'b1;
        tick();
        aStb = 1'b0;
        tick();
        vectors++; if (aAck !== 1'b1) begin miscompares++; $display("[TB] FAIL rd_ack: got %b want 1", aAck); end
        vectors++; if (aDatO !== 32'hDEADBEEF) begin miscompares++; $display("[TB] FAIL rd_dat: got %h want deadbeef", aDatO); end
        tick();
    endtask

    task automatic test_partial_write();
        aWe = 1'b1; aAdr = 12'h010; aDat = 32'h0000AA00; aSel = 4'b0010; aStb = 1'b1;
        tick();
        aStb = 1'b0;
        tick();
        vectors++; if (aAck !== 1'b1) begin miscompares++; $display("[TB] FAIL pw_ack: got %b want 1", aAck); end
        vectors++; if (aDatO !== 32'hDEADBEEF) begin miscompares++; $display("[TB] FAIL pw_dat_hold: got %h want deadbeef", aDatO); end
        aWe = 1'b0; aSel = 4'hF; aStb = 1'b1;
        tick();
        aStb = 1'b0;
        tick();
        vectors++; if (aAck !== 1'b1) begin miscompares++; $display("[TB] FAIL pr_ack: got %b want 1", aAck); end
        vectors++; if (aDatO !== 32'hDEADAAEF) begin miscompares++; $display("[TB] FAIL pr_dat: got %h want deadaaef", aDatO); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] dataTab [3];
        logic [31:0] expDat  [6];
        dataTab = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
        expDat  = '{32'hDEADAAEF, 32'hDEADAAEF, 32'hDEADAAEF, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
        aStb = 1'b1; aWe = 1'b1; aAdr = 12'h020; aDat = dataTab[0]; aSel = 4'hF;
        for (int i = 0; i < 7; i++) begin
            vectors++; if (aStall !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_stall[%0d]: got %b want 0", i, aStall); end
            tick();
            if (i + 1 < 6) begin
                aWe  = (i + 1 < 3);
                aAdr = 12'h020 + 12'((i + 1) % 3);
                aDat = dataTab[(i + 1) % 3];
            end else begin
                aStb = 1'b0;
            end
            if (i == 0) begin
                vectors++; if (aAck !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_ack0: got %b want 0", aAck); end
            end else begin
                vectors++; if (aAck !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_ack[%0d]: got %b want 1", i - 1, aAck); end
                vectors++; if (aDatO !== expDat[i-1]) begin miscompares++; $display("[TB] FAIL b2b_dat[%0d]: got %h want %h", i - 1, aDatO, expDat[i-1]); end
            end
        end
        tick();
        vectors++; if (aAck !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_tail: got %b want 0", aAck); end
    endtask

    task automatic test_error();
        aWe = 1'b0; aAdr = 12'h400; aSel = 4'hF; aStb = 1'b1;
        tick();
        aStb = 1'b0;
        tick();
        vectors++; if ({aAck, aErr} !== 2'b01) begin miscompares++; $display("[TB] FAIL err_resp: got ack,err=%b want 01", {aAck, aErr}); end
        vectors++; if (aDatO !== 32'h0) begin miscompares++; $display("[TB] FAIL err_dat: got %h want 0", aDatO); end
        tick();
        vectors++; if ({aAck, aErr} !== 2'b00) begin miscompares++; $display("[TB] FAIL err_pulse: got %b want 00", {aAck, aErr}); end
    endtask

    task automatic wait_head_wait3();
        bit found = 1'b0;
        for (int t = 0; t < 64 && !found; t++) begin
            if (lfsrModel[2:1] == 2'b11) found = 1'b1;
            else tick();
        end
        vectors++; if (!found) begin miscompares++; $display("[TB] FAIL lfsr_wait3: got none want 2'b11 within 64 cycles"); end
    endtask

    task automatic test_stall_full();
        int idx = 0, resp = 0, acc = 0, occ;
        bit sawFull = 1'b0, willAcc, got;
        for (int i = 0; i < 6; i++) begin
            bWe = 1'b1; bAdr = 12'h100 + 12'(i); bDat = 32'hB0B0_0000 + 32'(i); bSel = 4'hF; bStb = 1'b1;
            tick();
            bStb = 1'b0;
            got = 1'b0;
            for (int t = 0; t < 10 && !got; t++) begin
                tick();
                if (bAck) got = 1'b1;
            end
            vectors++; if (!got) begin miscompares++; $display("[TB] FAIL fill_wr_ack[%0d]: got none want ack", i); end
        end
        wait_head_wait3();
        bWe = 1'b0; bAdr = 12'h100; bStb = 1'b1;
        for (int t = 0; t < 60 && resp < 6; t++) begin
            willAcc = bStb && !bStall;
            tick();
            if (willAcc) begin acc++; idx++; end
            vectors++; if (bErr !== 1'b0) begin miscompares++; $display("[TB] FAIL fill_err: got %b want 0", bErr); end
            if (bAck) begin
                vectors++; if (bDatO !== 32'hB0B0_0000 + 32'(resp)) begin miscompares++; $display("[TB] FAIL fill_order[%0d]: got %h want %h", resp, bDatO, 32'hB0B0_0000 + 32'(resp)); end
                resp++;
            end
            occ = acc - resp;
            vectors++; if (bStall !== (occ == 4)) begin miscompares++; $display("[TB] FAIL fill_stall: got %b want %b (occ %0d)", bStall, occ == 4, occ); end
            if (bStall && occ == 4) sawFull = 1'b1;
            if (idx < 6) begin bStb = 1'b1; bAdr = 12'h100 + 12'(idx); end
            else bStb = 1'b0;
        end
        bStb = 1'b0;
        vectors++; if (resp != 6) begin miscompares++; $display("[TB] FAIL fill_count: got %0d want 6", resp); end
        vectors++; if (!sawFull) begin miscompares++; $display("[TB] FAIL fill_full: got no stall at 4 outstanding want stall"); end
    endtask

    task automatic test_cyc_drop();
        bit got = 1'b0;
        tick();
        wait_head_wait3();
        bWe = 1'b0; bSel = 4'hF;
        for (int i = 0; i < 3; i++) begin
            bAdr = 12'h100 + 12'(i); bStb = 1'b1;
            tick();
        end
        bStb = 1'b0;
        vectors++; if ({bAck, bStall} !== 2'b00) begin miscompares++; $display("[TB] FAIL drop_pre: got ack,stall=%b want 00", {bAck, bStall}); end
        bCyc = 1'b0;
        tick();
        vectors++; if ({bAck, bErr, bStall} !== 3'b000) begin miscompares++; $display("[TB] FAIL drop_next: got %b want 000", {bAck, bErr, bStall}); end
        for (int i = 0; i < 12; i++) begin
            if (i == 8) bCyc = 1'b1;
            tick();
            vectors++; if ({bAck, bErr} !== 2'b00) begin miscompares++; $display("[TB] FAIL drop_quiet[%0d]: got %b want 00", i, {bAck, bErr}); end
        end
        bAdr = 12'h105; bStb = 1'b1;
        tick();
        bStb = 1'b0;
        for (int t = 0; t < 10 && !got; t++) begin
            tick();
            if (bAck) got = 1'b1;
        end
        vectors++; if (!got || bDatO !== 32'hB0B0_0005) begin miscompares++; $display("[TB] FAIL drop_after: got ack=%b dat=%h want 1 b0b00005", got, bDatO); end
    endtask

    task automatic test_reset_mid_burst();
        aWe = 1'b0; aSel = 4'hF; aAdr = 12'h010; aStb = 1'b1;
        tick();
        aAdr = 12'h020;
        tick();
        aAdr = 12'h021;
        tick();
        aStb = 1'b0;
        vectors++; if (aAck !== 1'b1 || aDatO !== 32'h1111_1111) begin miscompares++; $display("[TB] FAIL mid_pre: got ack=%b dat=%h want 1 11111111", aAck, aDatO); end
        #2 reset = 1'b1;
        #1;
        vectors++; if ({aAck, aErr, aStall} !== 3'b000) begin miscompares++; $display("[TB] FAIL mid_rst_flags: got %b want 000", {aAck, aErr, aStall}); end
        vectors++; if (aDatO !== 32'h0) begin miscompares++; $display("[TB] FAIL mid_rst_dat: got %h want 0", aDatO); end
        vectors++; if (cStall !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_rst_stallC: got %b want 1", cStall); end
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++; if ({aAck, aErr} !== 2'b00) begin miscompares++; $display("[TB] FAIL mid_lost[%0d]: got %b want 00", i, {aAck, aErr}); end
        end
        aAdr = 12'h010; aStb = 1'b1;
        tick();
        aStb = 1'b0;
        tick();
        vectors++; if (aAck !== 1'b1 || aDatO !== 32'hDEADAAEF) begin miscompares++; $display("[TB] FAIL mid_fresh: got ack=%b dat=%h want 1 deadaaef", aAck, aDatO); end
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_stall_lfsr();
        test_write_read();
        test_partial_write();
        test_back_to_back();
        test_error();
        test_stall_full();
        test_cyc_drop();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
